dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RV32I pipeline. It is the memory-side end of the load/store interface that the MEM stage drives. It accepts one load or store request at a time over a valid/ready handshake, models a programmable number of wait states, and performs little-endian byte, half or word access on an internal word array. It returns the sign- or zero-extended load data, or a store acknowledge, over a second valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 10, byte-address width; array depth is 2^(ADDR_W-2) words.
- WAIT_CYCLES, 2, wait states between request acceptance and the array access (0..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_type  in  2  01 = read, 10 = write; 00 and 11 are illegal.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was illegal or misaligned.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) at an edge latches type, addr, size, unsigned and wdata.
  - If WAIT_CYCLES=0, the access is performed at that same edge and the FSM goes to RESP.
  - Otherwise the FSM goes to WAIT with cnt=WAIT_CYCLES-1.
- WAIT: req_ready=0.
  - If cnt=0, perform the access and go to RESP.
  - Otherwise decrement cnt.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err hold steady.
  - When rsp_ready=1 at an edge, go to IDLE.
  - A new request cannot be accepted in the same edge, because req_ready=0 in RESP.
- Access rules:
  - Word index is addr[ADDR_W-1:2]; lane is addr[1:0].
  - Error if type is 00 or 11, size is 11, size is half with addr[0]=1, or size is word with addr[1:0]≠00.
  - An error performs no array write and returns rsp_err=1, rsp_rdata=0.
  - Byte read: lane addr[1:0] is extended from bit 7.
  - Half read: lane addr[1] is extended from bit 15.
  - Word read: req_unsigned is ignored.
  - A write updates only the addressed byte lanes, with wdata[7:0] or wdata[15:0] placed in the lane. Other lanes are untouched. rsp_rdata=0, rsp_err=0.
- The array has no reset. Its contents are unaffected by reset.

## Timing
- Outputs at reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, cnt=0. req_ready goes to 1 in the first cycle after reset deasserts.
- Latency: a request accepted at edge E produces rsp_valid=1 in the cycle after edge E+WAIT_CYCLES. That is WAIT_CYCLES+1 cycles from the accept cycle.
- Throughput is one request per WAIT_CYCLES+2 cycles when rsp_ready is held high.
- Back-pressure: RESP holds indefinitely while rsp_ready=0, with outputs stable.
- The array write occurs exactly once per store, at the access edge, never while in RESP.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Request inputs are sampled only at the accept edge. Changes on them during WAIT or RESP have no effect.
- Reset mid-operation:
  - Reset asserted in WAIT aborts the request with no array write.
  - Reset asserted in RESP drops the response.
  - In both cases the outputs return to their reset values at the next edge.
- req_valid=1 while in WAIT or RESP is ignored and is not queued.

## Test plan
- Reset, then store word 0xDEADBEEF at addr 0x010, then load word at 0x010 (WAIT_CYCLES=2) -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid rises 3 cycles after the accept cycle.
- Byte load at 0x013 signed, then unsigned, on that word -> 0xFFFFFFDE then 0x000000DE. Half load at 0x012 signed -> 0xFFFFDEAD.
- Store byte 0x55 to 0x011, then load word 0x010 -> 0xDEAD55EF. Store half 0x1234 to 0x012 -> word reads 0x123455EF.
- Misaligned word load at 0x012, half store at 0x013, size=11, and type=00 -> each gives rsp_err=1, rsp_rdata=0, and the array is unchanged (word 0x010 still reads 0x123455EF).
- Hold rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid and data stay stable, and a pulsed req_valid is not accepted. Then release -> IDLE and req_ready=1 on the next cycle.
- Assert reset in WAIT during a store of 0xA5A5A5A5 to 0x020 -> all outputs go to 0, and a later load of 0x020 returns the previous contents. Repeat with WAIT_CYCLES=0 -> rsp_valid=1 in the cycle after accept.

Source files
------------

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory
// responder (slave).
interface dmem_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_type, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_type, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, programmable wait states,
// little-endian byte/half/word access on an unreset word array.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  dmem_if.slave bus
);
  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              ready_reg, ready_next;
  logic [1:0]        type_reg, size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              uns_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       word_reg;
  logic              load_reg, err_reg;

  logic [31:0] mem [DEPTH];

  logic              accept, access;
  logic [1:0]        acc_type, acc_size;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_err, acc_load, acc_store;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       rd_ext;

  assign accept = bus.req_valid & ready_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    access     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            access     = 1'b1;
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    ready_next = (state_next == IDLE);
  end

  // With zero wait states the access happens on the accept edge, so the
  // request comes straight from the bus rather than the latched copy.
  always_comb begin
    acc_type  = (state_reg == IDLE) ? bus.req_type  : type_reg;
    acc_size  = (state_reg == IDLE) ? bus.req_size  : size_reg;
    acc_addr  = (state_reg == IDLE) ? bus.req_addr  : addr_reg;
    acc_wdata = (state_reg == IDLE) ? bus.req_wdata : wdata_reg;
    acc_err   = (acc_type == 2'b00) || (acc_type == 2'b11) || (acc_size == 2'b11) ||
                ((acc_size == 2'b01) && acc_addr[0]) ||
                ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));
    acc_load  = (acc_type == 2'b01) && !acc_err;
    acc_store = (acc_type == 2'b10) && !acc_err;
    case (acc_size)
      2'b00: begin
        be    = 4'b0001 << acc_addr[1:0];
        wlane = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{acc_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = acc_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && access) begin
      word_reg <= mem[acc_addr[ADDR_W-1:2]];
      if (acc_store) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[acc_addr[ADDR_W-1:2]][8*b +: 8] <= wlane[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      ready_reg <= 1'b0;
      load_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= ready_next;
      if (access) begin
        load_reg <= acc_load;
        err_reg  <= acc_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && accept) begin
      type_reg  <= bus.req_type;
      size_reg  <= bus.req_size;
      addr_reg  <= bus.req_addr;
      uns_reg   <= bus.req_unsigned;
      wdata_reg <= bus.req_wdata;
    end
  end

  always_comb begin
    rd_byte = word_reg[{addr_reg[1:0], 3'b000} +: 8];
    rd_half = addr_reg[1] ? word_reg[31:16] : word_reg[15:0];
    case (size_reg)
      2'b00:   rd_ext = uns_reg ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = uns_reg ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rd_ext = word_reg;
    endcase
  end

  assign bus.req_ready = ready_reg;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_err   = err_reg;
  assign bus.rsp_rdata = load_reg ? rd_ext : 32'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states and
// one with none, driven through per-instance signal arrays.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, req_valid, rsp_ready, req_unsigned;
  logic [1:0]  req_ready, rsp_valid, rsp_err;
  logic [1:0]  req_type [2];
  logic [9:0]  req_addr [2];
  logic [1:0]  req_size [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  dmem_if #(.ADDR_W(10)) bus_a ();
  dmem_if #(.ADDR_W(10)) bus_b ();

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (.clk(clk), .reset(rst[0]), .bus(bus_a));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (.clk(clk), .reset(rst[1]), .bus(bus_b));

  assign bus_a.req_valid    = req_valid[0];
  assign bus_a.req_type     = req_type[0];
  assign bus_a.req_addr     = req_addr[0];
  assign bus_a.req_size     = req_size[0];
  assign bus_a.req_unsigned = req_unsigned[0];
  assign bus_a.req_wdata    = req_wdata[0];
  assign bus_a.rsp_ready    = rsp_ready[0];
  assign req_ready[0]       = bus_a.req_ready;
  assign rsp_valid[0]       = bus_a.rsp_valid;
  assign rsp_rdata[0]       = bus_a.rsp_rdata;
  assign rsp_err[0]         = bus_a.rsp_err;

  assign bus_b.req_valid    = req_valid[1];
  assign bus_b.req_type     = req_type[1];
  assign bus_b.req_addr     = req_addr[1];
  assign bus_b.req_size     = req_size[1];
  assign bus_b.req_unsigned = req_unsigned[1];
  assign bus_b.req_wdata    = req_wdata[1];
  assign bus_b.rsp_ready    = rsp_ready[1];
  assign req_ready[1]       = bus_b.req_ready;
  assign rsp_valid[1]       = bus_b.rsp_valid;
  assign rsp_rdata[1]       = bus_b.rsp_rdata;
  assign rsp_err[1]         = bus_b.rsp_err;

  int n_vec = 0;
  int n_bad = 0;
  logic [32:0] exp_q [$];

  localparam logic [1:0] RD = 2'b01, WR = 2'b10, SB = 2'b00, SH = 2'b01, SW = 2'b10;

  task automatic drive_req(input int d, input logic [1:0] typ, input logic [9:0] addr,
                           input logic [1:0] size, input logic uns, input logic [31:0] wd);
    req_type[d]     = typ;
    req_addr[d]     = addr;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_wdata[d]    = wd;
    req_valid[d]    = 1'b1;
  endtask

  // Full transaction: push expectation, handshake, scramble inputs, check latency and data.
  task automatic issue(input int d, input logic [1:0] typ, input logic [9:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e, input int hold,
                       input string name);
    int lat;
    int exp_lat;
    bit got;
    logic [32:0] exp;
    exp_lat = (d == 0) ? 3 : 1;
    exp_q.push_back({exp_d, exp_e});
    @(posedge clk); #1;
    drive_req(d, typ, addr, size, uns, wd);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[d]) got = 1;
    end
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s accept: req_ready=%b required 1", name, req_ready[d]);
      req_valid[d] = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clk); #1;
    req_valid[d]    = 1'b0;
    req_type[d]     = ~typ;
    req_addr[d]     = addr ^ 10'h3ff;
    req_size[d]     = ~size;
    req_unsigned[d] = ~uns;
    req_wdata[d]    = ~wd;
    got = 0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin
        got = 1;
        lat = i;
      end
    end
    exp = exp_q.pop_front();
    n_vec++;
    if (lat !== exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (rsp_rdata[d] !== exp[32:1]) begin
      n_bad++;
      $display("FAIL %s rdata: got %h required %h", name, rsp_rdata[d], exp[32:1]);
    end
    n_vec++;
    if (rsp_err[d] !== exp[0]) begin
      n_bad++;
      $display("FAIL %s err: got %b required %b", name, rsp_err[d], exp[0]);
    end
    $display("txn dut%0d %s type=%b addr=%h size=%b uns=%b wdata=%h -> rdata=%h err=%b lat=%0d",
             d, name, typ, addr, size, uns, wd, rsp_rdata[d], rsp_err[d], lat);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      drive_req(d, RD, 10'h010, SW, 1'b0, 32'h0);
      @(negedge clk);
      n_vec++;
      if (rsp_valid[d] !== 1'b1 || req_ready[d] !== 1'b0 ||
          rsp_rdata[d] !== exp[32:1] || rsp_err[d] !== exp[0]) begin
        n_bad++;
        $display("FAIL %s hold%0d: valid=%b ready=%b rdata=%h err=%b required 1 0 %h %b",
                 name, h, rsp_valid[d], req_ready[d], rsp_rdata[d], rsp_err[d], exp[32:1], exp[0]);
      end
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s release: valid=%b ready=%b required 0 1", name, rsp_valid[d], req_ready[d]);
    end
    if (hold > 0) begin
      @(negedge clk);
      n_vec++;
      if (rsp_valid[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL %s queued: rsp_valid=%b required 0", name, rsp_valid[d]);
      end
    end
  endtask

  task automatic check_cleared(input int d, input string name);
    n_vec++;
    if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'd0 || rsp_err[d] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: ready=%b valid=%b rdata=%h err=%b required all 0",
               name, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
    end
  endtask

  task automatic test_reset(input int d);
    @(posedge clk); #1;
    rst[d] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared(d, "reset_outputs");
    @(posedge clk); #1;
    rst[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (req_ready[d] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready dut%0d: got %b required 1", d, req_ready[d]);
    end
    $display("txn dut%0d reset done", d);
  endtask

  task automatic test_loads_stores;
    issue(0, WR, 10'h010, SW, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 0, "st_word");
    issue(0, RD, 10'h010, SW, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0, "ld_word");
    issue(0, RD, 10'h013, SB, 1'b0, 32'h0, 32'hFFFFFFDE, 1'b0, 0, "ld_byte_s");
    issue(0, RD, 10'h013, SB, 1'b1, 32'h0, 32'h000000DE, 1'b0, 0, "ld_byte_u");
    issue(0, RD, 10'h012, SH, 1'b0, 32'h0, 32'hFFFFDEAD, 1'b0, 0, "ld_half_s");
    issue(0, WR, 10'h011, SB, 1'b0, 32'hFFFFFF55, 32'h0, 1'b0, 0, "st_byte");
    issue(0, RD, 10'h010, SW, 1'b0, 32'h0, 32'hDEAD55EF, 1'b0, 0, "ld_after_sb");
    issue(0, RD, 10'h011, SB, 1'b0, 32'h0, 32'h00000055, 1'b0, 0, "ld_byte_pos");
    issue(0, WR, 10'h012, SH, 1'b0, 32'hABCD1234, 32'h0, 1'b0, 0, "st_half");
    issue(0, RD, 10'h010, SW, 1'b1, 32'h0, 32'h123455EF, 1'b0, 0, "ld_after_sh");
    issue(0, RD, 10'h010, SH, 1'b1, 32'h0, 32'h000055EF, 1'b0, 0, "ld_half_u");
  endtask

  task automatic test_errors;
    issue(0, RD, 10'h012, SW, 1'b0, 32'h0, 32'h0, 1'b1, 0, "err_mis_word");
    issue(0, WR, 10'h013, SH, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 0, "err_mis_half");
    issue(0, WR, 10'h010, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 0, "err_size11");
    issue(0, 2'b00, 10'h010, SW, 1'b0, 32'h0, 32'h0, 1'b1, 0, "err_type00");
    issue(0, 2'b11, 10'h010, SW, 1'b0, 32'h0, 32'h0, 1'b1, 0, "err_type11");
    issue(0, RD, 10'h010, SW, 1'b0, 32'h0, 32'h123455EF, 1'b0, 0, "ld_after_err");
  endtask

  task automatic test_backpressure;
    issue(0, RD, 10'h010, SW, 1'b0, 32'h0, 32'h123455EF, 1'b0, 5, "backpressure");
  endtask

  task automatic test_reset_in_wait;
    bit got;
    issue(0, WR, 10'h020, SW, 1'b0, 32'h0BADF00D, 32'h0, 1'b0, 0, "st_prev");
    @(posedge clk); #1;
    drive_req(0, WR, 10'h020, SW, 1'b0, 32'hA5A5A5A5);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
    end
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL abort_accept: req_ready=%b required 1", req_ready[0]);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(negedge clk);
    check_cleared(0, "abort_wait_outputs");
    $display("txn dut0 store A5A5A5A5 @020 aborted by reset");
    issue(0, RD, 10'h020, SW, 1'b0, 32'h0, 32'h0BADF00D, 1'b0, 0, "ld_after_abort");
  endtask

  task automatic test_zero_wait;
    bit got;
    issue(1, WR, 10'h004, SW, 1'b0, 32'h11223344, 32'h0, 1'b0, 0, "w0_st_word");
    issue(1, RD, 10'h004, SW, 1'b0, 32'h0, 32'h11223344, 1'b0, 0, "w0_ld_word");
    issue(1, RD, 10'h006, SH, 1'b1, 32'h0, 32'h00001122, 1'b0, 0, "w0_ld_half_u");
    issue(1, RD, 10'h005, SB, 1'b0, 32'h0, 32'h00000033, 1'b0, 2, "w0_backpressure");
    // reset while the response is pending drops it
    @(posedge clk); #1;
    drive_req(1, RD, 10'h004, SW, 1'b0, 32'h0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid[1]) got = 1;
    end
    n_vec++;
    if (!got || rsp_rdata[1] !== 32'h11223344) begin
      n_bad++;
      $display("FAIL w0_resp_before_reset: valid=%b rdata=%h required 1 11223344", rsp_valid[1], rsp_rdata[1]);
    end
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(negedge clk);
    check_cleared(1, "reset_in_resp");
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_resp_after: ready=%b valid=%b required 1 0", req_ready[1], rsp_valid[1]);
    end
    $display("txn dut1 response dropped by reset");
  endtask

  initial begin
    rst          = 2'b00;
    req_valid    = 2'b00;
    rsp_ready    = 2'b00;
    req_unsigned = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req_type[d]  = 2'b00;
      req_addr[d]  = 10'h0;
      req_size[d]  = 2'b00;
      req_wdata[d] = 32'h0;
    end
    test_reset(0);
    test_reset(1);
    test_loads_stores();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_zero_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
